conv_layer_sched: RTL

//  Layer-level scheduler for the 3x3 convolve engine. Accepts one layer config, then loops kernels
//  (outer) x output rows (inner). Per run: request a row-buffer fill at the correct input row, pulse
//  eng_start, wait for eng_done, advance. Sits between the NPU command decoder and convolve/row buffers.

---
 rtl/npu_pkg.sv | 8 +
 rtl/sched_timeout_cnt.sv | 18 +
 rtl/conv_layer_sched.sv | 130 +++++++++++++
 3 files changed

// File: rtl/npu_pkg.sv
// npu_pkg: shared scheduler state encoding and layer geometry defaults
package npu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_START, S_WAIT_DONE, S_NEXT, S_FINISH} sched_state_e;
  localparam int IMG_H_DEF = 28;
  localparam int KW_DEF = 3;
  localparam int ROWS_S1 = IMG_H_DEF - KW_DEF + 1;
  localparam int ROWS_S2 = (IMG_H_DEF - KW_DEF) / 2 + 1;
endpackage

// File: rtl/sched_timeout_cnt.sv
// sched_timeout_cnt: clearable up-counter flagging the last permitted wait cycle
module sched_timeout_cnt #(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  assign expire_o = en_i && cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: loops kernels x output rows, driving row-buffer fills and convolve runs
module conv_layer_sched
  import npu_pkg::*;
#(
  parameter int IMG_H = IMG_H_DEF,
  parameter int KW = KW_DEF,
  parameter int TIMEOUT_CYC = 1023,
  parameter int KSEL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_stride,
  input  logic              cfg_pool_en,
  input  logic [KSEL_W-1:0] cfg_num_kern,
  output logic              rowbuf_load,
  input  logic              rowbuf_ready,
  output logic [4:0]        row_base,
  output logic              eng_start,
  input  logic              eng_done,
  output logic [1:0]        eng_stride,
  output logic              eng_pool_en,
  output logic [4:0]        eng_dest_addr,
  output logic [KSEL_W-1:0] kernel_sel,
  output logic [4:0]        dest_row,
  output logic              busy,
  output logic              layer_done,
  output logic              err_timeout
);
  localparam logic [4:0] ROWS1 = 5'(IMG_H - KW + 1);
  localparam logic [4:0] ROWS2 = 5'((IMG_H - KW) / 2 + 1);
  sched_state_e state_q;
  logic [1:0] stride_q, cfg_s;
  logic pool_q, rowbuf_load_q, eng_start_q, layer_done_q, err_q, done_prev_q;
  logic [KSEL_W-1:0] nk_q, kern_q, kern_d, kernel_sel_q;
  logic [4:0] rows_q, row_q, row_d, row_base_q, dest_row_q;
  logic last_row, done_rise, expire;
  always_comb begin
    cfg_s = cfg_stride == 2'd2 ? 2'd2 : 2'd1;
    last_row = row_q == rows_q - 5'd1;
    row_d = last_row ? 5'd0 : row_q + 5'd1;
    kern_d = last_row ? kern_q + KSEL_W'(1) : kern_q;
    done_rise = eng_done & ~done_prev_q;
  end
  sched_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == S_START),
    .en_i(state_q == S_WAIT_DONE),
    .expire_o(expire)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      stride_q <= '0;
      pool_q <= 1'b0;
      nk_q <= '0;
      rows_q <= '0;
      row_q <= '0;
      kern_q <= '0;
      row_base_q <= '0;
      dest_row_q <= '0;
      kernel_sel_q <= '0;
      rowbuf_load_q <= 1'b0;
      eng_start_q <= 1'b0;
      layer_done_q <= 1'b0;
      err_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= eng_done;
      rowbuf_load_q <= 1'b0;
      eng_start_q <= 1'b0;
      layer_done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cfg_valid) begin
          stride_q <= cfg_s;
          pool_q <= cfg_pool_en;
          nk_q <= cfg_num_kern;
          rows_q <= cfg_s == 2'd2 ? ROWS2 : ROWS1;
          row_q <= '0;
          kern_q <= '0;
          row_base_q <= '0;
          dest_row_q <= '0;
          kernel_sel_q <= '0;
          err_q <= 1'b0;
          rowbuf_load_q <= 1'b1;
          state_q <= S_FILL;
        end
        S_FILL: if (rowbuf_ready) begin
          eng_start_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: state_q <= S_WAIT_DONE;
        S_WAIT_DONE: if (done_rise) state_q <= S_NEXT;
          else if (expire) begin
            err_q <= 1'b1;
            state_q <= S_IDLE;
          end
        S_NEXT: begin
          row_q <= row_d;
          kern_q <= kern_d;
          row_base_q <= stride_q == 2'd2 ? {row_d[3:0], 1'b0} : row_d;
          dest_row_q <= pool_q ? {1'b0, row_d[4:1]} : row_d;
          kernel_sel_q <= kern_d;
          if (last_row && kern_q == nk_q) begin
            layer_done_q <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            rowbuf_load_q <= 1'b1;
            state_q <= S_FILL;
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  assign cfg_ready = state_q == S_IDLE;
  assign busy = state_q != S_IDLE;
  assign rowbuf_load = rowbuf_load_q;
  assign eng_start = eng_start_q;
  assign layer_done = layer_done_q;
  assign err_timeout = err_q;
  assign row_base = row_base_q;
  assign dest_row = dest_row_q;
  assign kernel_sel = kernel_sel_q;
  assign eng_stride = stride_q;
  assign eng_pool_en = pool_q;
  assign eng_dest_addr = '0;
endmodule
